control_sequencer: RTL

- Hardwired control unit that drives the datapath's control inputs, directly upstream of the datapath.
- Sequences fetch (T0–T2), then per-opcode execute steps decoded from IR.
- Handles the multi-cycle divider handshake (reset_div / calc_finished) and conditional branches via CON_output.
- Stops on halt or on an illegal opcode.

---
 rtl/control_sequencer.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, per-opcode execute steps,
// divider start/wait handshake with timeout, and a HALT sink state.
//
// Handshake with the divider: reset_div is a one-cycle start pulse in T4;
// the sequencer then waits in DIVWAIT, holding the operand selects, until it
// sees calc_finished=1. That same cycle loads Zhi/Zlo, so calc_finished only
// has to be valid for that one cycle. calc_finished is ignored in T4.
module control_sequencer #(
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_output,
    input  logic        calc_finished,
    output logic [4:0]  op_sel,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        BAout,
    output logic        Rin,
    output logic        R_out,
    output logic        MAR_rd,
    output logic        MDR_rd,
    output logic        IR_rd,
    output logic        Y_rd,
    output logic        PC_rd,
    output logic        HI_rd,
    output logic        LO_rd,
    output logic        Zhi_rd,
    output logic        Zlo_rd,
    output logic        Out_rd,
    output logic        CONin,
    output logic        PC_out,
    output logic        MDR_out,
    output logic        Zlo_out,
    output logic        Zhi_out,
    output logic        HI_out,
    output logic        LO_out,
    output logic        In_out,
    output logic        C_out,
    output logic        reset_div,
    output logic        run,
    output logic        fault,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_T0      = 4'd0,
        S_T1      = 4'd1,
        S_T2      = 4'd2,
        S_T3      = 4'd3,
        S_T4      = 4'd4,
        S_T5      = 4'd5,
        S_T6      = 4'd6,
        S_T7      = 4'd7,
        S_DIVWAIT = 4'd8,
        S_HALT    = 4'd9
    } state_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       opcode;
    logic [4:0]       imm_sel;
    logic             unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign fault     = fault_q;
    assign dbg_state = state_q;

    // Immediate forms reuse the register-form ALU operation.
    always_comb begin
        imm_sel = OP_ADD;
        case (opcode)
            OP_ANDI: imm_sel = OP_AND;
            OP_ORI:  imm_sel = OP_OR;
            default: imm_sel = OP_ADD;
        endcase
    end

    // State, sticky fault flag and divider wait counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_T0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Moore control decode; everything is forced low while clr is high.
    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        cnt_d     = cnt_q;
        op_sel    = 5'b00000;
        IncPC     = 1'b0;  Read    = 1'b0;  Write   = 1'b0;
        Gra       = 1'b0;  Grb     = 1'b0;  Grc     = 1'b0;
        BAout     = 1'b0;  Rin     = 1'b0;  R_out   = 1'b0;
        MAR_rd    = 1'b0;  MDR_rd  = 1'b0;  IR_rd   = 1'b0;
        Y_rd      = 1'b0;  PC_rd   = 1'b0;  HI_rd   = 1'b0;
        LO_rd     = 1'b0;  Zhi_rd  = 1'b0;  Zlo_rd  = 1'b0;
        Out_rd    = 1'b0;  CONin   = 1'b0;  PC_out  = 1'b0;
        MDR_out   = 1'b0;  Zlo_out = 1'b0;  Zhi_out = 1'b0;
        HI_out    = 1'b0;  LO_out  = 1'b0;  In_out  = 1'b0;
        C_out     = 1'b0;  reset_div = 1'b0; run   = 1'b0;

        if (!clr) begin
            run = (state_q != S_HALT);
            case (state_q)
                S_T0: begin
                    PC_out = 1'b1; MAR_rd = 1'b1; IncPC = 1'b1;
                    state_d = S_T1;
                end
                S_T1: begin
                    Read = 1'b1; MDR_rd = 1'b1;
                    state_d = S_T2;
                end
                S_T2: begin
                    MDR_out = 1'b1; IR_rd = 1'b1;
                    state_d = S_T3;
                end
                S_T3: begin
                    state_d = S_T0;
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                        OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI: begin
                            Grb = 1'b1; R_out = 1'b1; Y_rd = 1'b1; state_d = S_T4;
                        end
                        OP_LD, OP_LDI, OP_ST: begin
                            Grb = 1'b1; BAout = 1'b1; Y_rd = 1'b1; state_d = S_T4;
                        end
                        OP_NEG, OP_NOT: begin
                            Grb = 1'b1; R_out = 1'b1; op_sel = opcode; Zlo_rd = 1'b1;
                            state_d = S_T4;
                        end
                        OP_MUL, OP_DIV: begin
                            Gra = 1'b1; R_out = 1'b1; Y_rd = 1'b1; state_d = S_T4;
                        end
                        OP_BR: begin
                            Gra = 1'b1; R_out = 1'b1; CONin = 1'b1; state_d = S_T4;
                        end
                        OP_JR:   begin Gra = 1'b1; R_out = 1'b1; PC_rd = 1'b1; end
                        OP_IN:   begin In_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_OUT:  begin Gra = 1'b1; R_out = 1'b1; Out_rd = 1'b1; end
                        OP_MFHI: begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_MFLO: begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_NOP:  state_d = S_T0;
                        OP_HALT: state_d = S_HALT;
                        default: begin
                            state_d = S_HALT;
                            fault_d = 1'b1;
                        end
                    endcase
                end
                S_T4: begin
                    state_d = S_T0;
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                        OP_ROR, OP_ROL: begin
                            Grc = 1'b1; R_out = 1'b1; op_sel = opcode; Zlo_rd = 1'b1;
                            state_d = S_T5;
                        end
                        OP_ADDI, OP_ANDI, OP_ORI: begin
                            C_out = 1'b1; op_sel = imm_sel; Zlo_rd = 1'b1; state_d = S_T5;
                        end
                        OP_LD, OP_LDI, OP_ST: begin
                            C_out = 1'b1; op_sel = OP_ADD; Zlo_rd = 1'b1; state_d = S_T5;
                        end
                        OP_NEG, OP_NOT: begin
                            Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        OP_MUL: begin
                            Grb = 1'b1; R_out = 1'b1; op_sel = opcode;
                            Zhi_rd = 1'b1; Zlo_rd = 1'b1; state_d = S_T5;
                        end
                        OP_DIV: begin
                            Grb = 1'b1; R_out = 1'b1; op_sel = opcode; reset_div = 1'b1;
                            cnt_d = '0; state_d = S_DIVWAIT;
                        end
                        OP_BR: begin
                            PC_out = 1'b1; Y_rd = 1'b1; state_d = S_T5;
                        end
                        default: state_d = S_T0;
                    endcase
                end
                S_T5: begin
                    state_d = S_T0;
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                        OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                            Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            Zlo_out = 1'b1; MAR_rd = 1'b1; state_d = S_T6;
                        end
                        OP_MUL, OP_DIV: begin
                            Zlo_out = 1'b1; LO_rd = 1'b1; state_d = S_T6;
                        end
                        OP_BR: begin
                            C_out = 1'b1; op_sel = OP_ADD; Zlo_rd = 1'b1; state_d = S_T6;
                        end
                        default: state_d = S_T0;
                    endcase
                end
                S_T6: begin
                    state_d = S_T0;
                    case (opcode)
                        OP_LD: begin Read = 1'b1; MDR_rd = 1'b1; state_d = S_T7; end
                        OP_ST: begin
                            Gra = 1'b1; R_out = 1'b1; MDR_rd = 1'b1; state_d = S_T7;
                        end
                        OP_MUL, OP_DIV: begin Zhi_out = 1'b1; HI_rd = 1'b1; end
                        OP_BR: begin
                            // Branch not taken: this step is an empty cycle.
                            if (CON_output) begin
                                Zlo_out = 1'b1; PC_rd = 1'b1;
                            end
                        end
                        default: state_d = S_T0;
                    endcase
                end
                S_T7: begin
                    state_d = S_T0;
                    case (opcode)
                        OP_LD:   begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_ST:   Write = 1'b1;
                        default: state_d = S_T0;
                    endcase
                end
                S_DIVWAIT: begin
                    Grb = 1'b1; R_out = 1'b1; op_sel = OP_DIV;
                    if (calc_finished) begin
                        Zhi_rd = 1'b1; Zlo_rd = 1'b1; state_d = S_T5;
                    end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_T0;
            endcase
        end
    end

endmodule
